// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light conflict monitor.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE         = 2'b00;
    localparam logic [1:0] FC_CONFLICT     = 2'b01;
    localparam logic [1:0] FC_DARK         = 2'b10;
    localparam logic [1:0] FC_SHORT_YELLOW = 2'b11;

    // Bit positions inside a 4-bit lamp vector
    localparam int GREEN  = 0;
    localparam int YELLOW = 1;
    localparam int LEFT   = 2;
    localparam int RED    = 3;

    localparam logic [3:0] LAMP_RED_ONLY = 4'b1000;

    // True when a direction shows any lamp that lets traffic move
    function automatic logic any_go(input logic [3:0] lamp);
        return lamp[GREEN] | lamp[YELLOW] | lamp[LEFT];
    endfunction

endpackage

// File: rtl/tlc_dir_checker.sv
// Per-direction sample checker: one-hot validity, consecutive-invalid run and yellow run length.
// Flags are combinational on the current sample; counters update at the edge and clear while disabled.
module tlc_dir_checker
    import tlc_pkg::*;
#(
    parameter int DARK_TOL   = 3,
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lamp,
    input  logic       check_en,
    output logic       valid,
    output logic       invalid_fault,
    output logic       short_yellow
);

    localparam int DW = $clog2(DARK_TOL + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);

    logic [DW-1:0] dark_cnt;
    logic [YW-1:0] yel_cnt;
    logic          prev_yellow;

    assign valid         = $onehot(lamp);
    assign invalid_fault = check_en && !valid && (dark_cnt == DW'(DARK_TOL - 1));
    // yel_cnt holds the run length that ended with the previous sample
    assign short_yellow  = check_en && prev_yellow && !lamp[YELLOW]
                           && (yel_cnt < YW'(MIN_YELLOW));

    always_ff @(posedge clk) begin
        if (reset || !check_en) begin
            dark_cnt    <= '0;
            yel_cnt     <= '0;
            prev_yellow <= 1'b0;
        end else begin
            if (valid)
                dark_cnt <= '0;
            else if (dark_cnt != DW'(DARK_TOL))
                dark_cnt <= dark_cnt + DW'(1);

            if (!lamp[YELLOW])
                yel_cnt <= '0;
            else if (yel_cnt != YW'(MIN_YELLOW))
                yel_cnt <= yel_cnt + YW'(1);

            prev_yellow <= lamp[YELLOW];
        end
    end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety stage after the TLC: passes legal lamp patterns with one cycle latency,
// latches the first violation and flashes both reds until reset.
module tlc_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int STARTUP    = 4,
    parameter int DARK_TOL   = 3,
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_HALF = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_green_in,
    input  logic       h_yellow_in,
    input  logic       h_left_in,
    input  logic       h_red_in,
    input  logic       v_green_in,
    input  logic       v_yellow_in,
    input  logic       v_left_in,
    input  logic       v_red_in,
    output logic       h_green_out,
    output logic       h_yellow_out,
    output logic       h_left_out,
    output logic       h_red_out,
    output logic       v_green_out,
    output logic       v_yellow_out,
    output logic       v_left_out,
    output logic       v_red_out,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int IW = $clog2(STARTUP + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    state_t        state, state_nxt;
    logic [IW-1:0] init_cnt, init_cnt_nxt;
    logic [FW-1:0] flash_cnt, flash_cnt_nxt;
    logic [3:0]    h_lamp_q, h_lamp_nxt;
    logic [3:0]    v_lamp_q, v_lamp_nxt;
    logic          fault_q, fault_nxt;
    logic [1:0]    code_q, code_nxt;

    logic [3:0] h_in, v_in;
    logic       check_en;
    logic       h_valid, h_inv, h_sy;
    logic       v_valid, v_inv, v_sy;
    logic       conflict, red_on;

    assign h_in     = {h_red_in, h_left_in, h_yellow_in, h_green_in};
    assign v_in     = {v_red_in, v_left_in, v_yellow_in, v_green_in};
    assign check_en = (state == ST_MONITOR);
    assign conflict = any_go(h_in) && any_go(v_in);

    tlc_dir_checker #(.DARK_TOL(DARK_TOL), .MIN_YELLOW(MIN_YELLOW)) u_h_chk (
        .clk(clk), .reset(reset), .lamp(h_in), .check_en(check_en),
        .valid(h_valid), .invalid_fault(h_inv), .short_yellow(h_sy)
    );

    tlc_dir_checker #(.DARK_TOL(DARK_TOL), .MIN_YELLOW(MIN_YELLOW)) u_v_chk (
        .clk(clk), .reset(reset), .lamp(v_in), .check_en(check_en),
        .valid(v_valid), .invalid_fault(v_inv), .short_yellow(v_sy)
    );

    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        flash_cnt_nxt = flash_cnt;
        h_lamp_nxt    = h_lamp_q;
        v_lamp_nxt    = v_lamp_q;
        fault_nxt     = fault_q;
        code_nxt      = code_q;
        red_on        = 1'b0;
        case (state)
            ST_INIT: begin
                h_lamp_nxt = LAMP_RED_ONLY;
                v_lamp_nxt = LAMP_RED_ONLY;
                if (init_cnt == IW'(STARTUP - 1))
                    state_nxt = ST_MONITOR;
                else
                    init_cnt_nxt = init_cnt + IW'(1);
            end
            ST_MONITOR: begin
                if (conflict || h_sy || v_sy || h_inv || v_inv) begin
                    state_nxt     = ST_FAULT;
                    fault_nxt     = 1'b1;
                    flash_cnt_nxt = '0;
                    h_lamp_nxt    = LAMP_RED_ONLY;
                    v_lamp_nxt    = LAMP_RED_ONLY;
                    if (conflict)
                        code_nxt = FC_CONFLICT;
                    else if (h_sy || v_sy)
                        code_nxt = FC_SHORT_YELLOW;
                    else
                        code_nxt = FC_DARK;
                end else begin
                    h_lamp_nxt = h_valid ? h_in : LAMP_RED_ONLY;
                    v_lamp_nxt = v_valid ? v_in : LAMP_RED_ONLY;
                end
            end
            ST_FAULT: begin
                // Phase 0..FLASH_HALF-1 is red-on; the fault edge itself was phase 0
                if (flash_cnt == FW'(2 * FLASH_HALF - 1))
                    flash_cnt_nxt = '0;
                else
                    flash_cnt_nxt = flash_cnt + FW'(1);
                red_on          = (flash_cnt_nxt < FW'(FLASH_HALF));
                h_lamp_nxt      = '0;
                v_lamp_nxt      = '0;
                h_lamp_nxt[RED] = red_on;
                v_lamp_nxt[RED] = red_on;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            flash_cnt <= '0;
            h_lamp_q  <= LAMP_RED_ONLY;
            v_lamp_q  <= LAMP_RED_ONLY;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            flash_cnt <= flash_cnt_nxt;
            h_lamp_q  <= h_lamp_nxt;
            v_lamp_q  <= v_lamp_nxt;
            fault_q   <= fault_nxt;
            code_q    <= code_nxt;
        end
    end

    assign h_green_out  = h_lamp_q[GREEN];
    assign h_yellow_out = h_lamp_q[YELLOW];
    assign h_left_out   = h_lamp_q[LEFT];
    assign h_red_out    = h_lamp_q[RED];
    assign v_green_out  = v_lamp_q[GREEN];
    assign v_yellow_out = v_lamp_q[YELLOW];
    assign v_left_out   = v_lamp_q[LEFT];
    assign v_red_out    = v_lamp_q[RED];
    assign fault        = fault_q;
    assign fault_code   = code_q;

endmodule
